// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader states and
// the geometry of the instruction memory it fills.
package imem_loader_pkg;

    // Instruction memory geometry, shared with the instruction memory and the PC.
    localparam int LOADER_DEPTH  = 16;
    localparam int LOADER_ADDR_W = 4;

    // Loader session states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Receives a framed program (LEN, LEN instruction bytes, CSUM) over a
// valid/ready byte stream, writes the bytes into the instruction memory and
// keeps the CPU in reset until the whole program has been loaded and its
// checksum has matched.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DATA_W = 8,
    parameter int DEPTH  = LOADER_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    // Largest legal LEN value, at the stream byte width.
    localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(DEPTH);

    loader_state_t     state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              in_ready_s;
    logic              xfer_s;

    // The loader only listens to the stream while a frame is in progress.
    assign in_ready_s = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign xfer_s     = in_valid && in_ready_s;

    // Next-state and next-output logic for the load session.
    always_comb begin
        state_d      = state_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        length_d     = length_q;
        sum_d        = sum_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                // A new session always starts from a clean count and checksum.
                if (start) begin
                    state_d      = LEN;
                    word_count_d = '0;
                    sum_d        = '0;
                end else begin
                    state_d = state_q;
                end
            end
            LEN: begin
                if (xfer_s) begin
                    if ((in_data == {DATA_W{1'b0}}) || (in_data > MAX_LEN)) begin
                        state_d = ERR;
                    end else begin
                        length_d = in_data[ADDR_W:0];
                        state_d  = DATA;
                    end
                end else begin
                    state_d = LEN;
                end
            end
            DATA: begin
                if (xfer_s) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_count_q[ADDR_W-1:0];
                    mem_wdata_d  = in_data;
                    word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
                    sum_d        = sum_q + in_data;
                    if (word_count_d == length_q) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            CSUM: begin
                if (xfer_s) begin
                    if (in_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    state_d = CSUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags follow the state they describe, on the same edge.
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERR);
        cpu_reset_d = (state_d != DONE);
    end

    // State and output registers; reset aborts any session and drops a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            length_q     <= '0;
            sum_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
            length_q     <= length_d;
            sum_q        <= sum_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as data
// bytes are driven and matched against every mem_we pulse; status outputs are
// compared against values derived from the frames.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       done;
    logic       error;
    logic [4:0] word_count;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] shadow_mem[16];
    logic [7:0] exp_mem[16];
    logic [7:0] payload[16];
    int         n_vec  = 0;
    int         n_miss = 0;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction memory stand-in plus scoreboard matching of each write pulse.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            shadow_mem[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and return at the negedge following its acceptance.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input logic [3:0] a);
        exp_q.push_back({a, b});
        exp_mem[a] = b;
        send_byte(b);
    endtask

    // Full frame from payload[0..len-1]; optional idle gaps and a stray start mid-DATA.
    task automatic send_frame(input int len, input logic [7:0] csum, input bit gaps, input bit start_mid);
        pulse_start();
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            send_data(payload[i], 4'(i));
            if (gaps) begin
                in_valid = 1'b0;
                if (start_mid && i == 1) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        send_byte(csum);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            shadow_mem[i] = 8'hEE;
            exp_mem[i]    = 8'hEE;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);

        // Basic three-word program
        payload[0] = 8'h85; payload[1] = 8'h92; payload[2] = 8'h16;
        send_frame(3, 8'h2D, 1'b0, 1'b0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t1_word_count", 32'(word_count), 32'd3);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_in_ready", 32'(in_ready), 32'd0);

        // Bad checksum, then recovery with the correct frame
        send_frame(3, 8'h2E, 1'b0, 1'b0);
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        send_frame(3, 8'h2D, 1'b0, 1'b0);
        chk("t2b_done", 32'(done), 32'd1);
        chk("t2b_error", 32'(error), 32'd0);

        // Illegal lengths 0x00 and 0x11
        pulse_start();
        chk("t3_start_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'h00);
        chk("t3a_error", 32'(error), 32'd1);
        chk("t3a_word_count", 32'(word_count), 32'd0);
        chk("t3a_mem_we", 32'(mem_we), 32'd0);
        pulse_start();
        send_byte(8'h11);
        chk("t3b_error", 32'(error), 32'd1);
        chk("t3b_word_count", 32'(word_count), 32'd0);
        chk("t3b_mem_we", 32'(mem_we), 32'd0);
        chk("t3b_done", 32'(done), 32'd0);

        // Full-depth program 01..10, checksum 0x88
        for (int i = 0; i < 16; i++) payload[i] = 8'(i + 1);
        send_frame(16, 8'h88, 1'b0, 1'b0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_word_count", 32'(word_count), 32'd16);
        chk("t4_last_addr", 32'(mem_addr), 32'hF);

        // Gapped stream with a start pulse during DATA
        payload[0] = 8'hA1; payload[1] = 8'hB2; payload[2] = 8'hC3; payload[3] = 8'hD4;
        send_frame(4, 8'hEA, 1'b1, 1'b1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_word_count", 32'(word_count), 32'd4);

        // Reset at the edge accepting the second DATA byte
        pulse_start();
        send_byte(8'h03);
        send_data(8'h5A, 4'h0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t6_word_count", 32'(word_count), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_mem0", 32'(shadow_mem[0]), 32'h5A);
        chk("t6_mem1", 32'(shadow_mem[1]), 32'hB2);

        // Every expected write seen, memory image consistent
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mem_%0d", i), 32'(shadow_mem[i]), 32'(exp_mem[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
